fft_out_reorder: RTL and testbench
==================================

FFT_OUT_REORDER -- requirements
Module: fft_out_reorder

Interface
REQ-001 SHALL have parameter DATA_W, default 34, meaning the packed complex sample width ({re[16:0], im[16:0]}, `cacheDataWid).
REQ-002 SHALL have parameter NPOINT, default 256, meaning the frame length; only 256 is supported (4 radix-4 digits).
REQ-003 SHALL have one clock and an asynchronous, active-high reset: clk input 1, rising-edge clock; rst input 1, async active-high reset.
REQ-004 in_valid input 1: a beat of four final-stage butterfly outputs is present.
REQ-005 in_ready output 1: block accepts the beat this cycle.
REQ-006 din0..din3 input DATA_W each: lane k output of the last-stage butterfly, k=0..3.
REQ-007 in_last input 1: asserted by the producer on beat 63 of a frame.
REQ-008 out_valid output 1: dout holds a valid natural-order bin.
REQ-009 out_ready input 1: consumer accepts dout this cycle.
REQ-010 dout output DATA_W: spectrum bin X[out_idx], same packing as din.
REQ-011 out_idx output 8: natural-order bin index 0..255.
REQ-012 out_last output 1: high with out_valid when out_idx==255.
REQ-013 frame_err output 1: sticky; set on in_last misalignment.

Function
REQ-014 SHALL contain two frame buffers (ping-pong) of 256 x DATA_W, each split into 4 banks of 64 rows (bank = lane).
REQ-015 Input handshake: beat accepted when in_valid && in_ready; in_ready = !full[wr_sel].
REQ-016 Write addressing: beat count b (0..63), lane k is stored at in-place address a = 4*b + k (bank k, row b) of buffer wr_sel.
REQ-017 On accepting beat b==63: set full[wr_sel], toggle wr_sel, clear b to 0; a beat is never written to a full buffer.
REQ-018 in_last high on a beat with b!=63, or low on a beat with b==63: set frame_err; the frame still completes on the count, not on in_last.
REQ-019 Read mapping: for output index m = d3d2d1d0 (base 4), read address = digit-reverse(m) = d0d1d2d3, i.e. bank = m[7:6], row = {m[1:0], m[3:2], m[5:4]}.
REQ-020 out_valid = full[rd_sel]; dout, out_idx and out_last are combinational from buffer rd_sel and read counter m; latency from the accepting edge of beat 63 to out_valid high is exactly 1 cycle when rd_sel points at that buffer.
REQ-021 Output handshake: m increments on out_valid && out_ready; dout/out_idx SHALL hold stable while out_valid && !out_ready.
REQ-022 On handshake with m==255: clear full[rd_sel], toggle rd_sel, m wraps to 0.
REQ-023 Simultaneous events: a set of full[wr_sel] and a clear of full[rd_sel] in the same cycle (different buffers) both take effect; with both buffers full, in_ready=0 until one drains.
REQ-024 Sustained throughput: 64 input beats per frame and 256 output cycles per frame; the input side stalls whenever the drain side lags by a whole frame.

Reset
REQ-025 On rst: in_ready=1, out_valid=0, out_idx=0, out_last=0, frame_err=0, wr_sel=0, rd_sel=0, full=2'b00, b=0, m=0; buffer contents are not reset.
REQ-026 Reset asserted mid-frame SHALL discard any partial or pending frame; the first beat after deassertion is beat 0 of buffer 0.

Structure
REQ-027 Width and field macros (`cacheDataWid, `xnRe, `xnIm, NPOINT-derived widths) SHALL reside in the shared define.v include.
REQ-028 One sub-module, reorder_bank (one 64 x DATA_W buffer bank with synchronous write and combinational read), SHALL be instantiated 8 times.
REQ-029 The digit-reverse mapping SHALL be a single function used for both reading and model checking.

Verification
REQ-030 Ramp: beat b lanes carry re=4b+k, im=0; out_ready=1 -> outputs appear 1 cycle after beat 63 with dout.re = digitrev(out_idx) for idx 0..255, e.g. idx 1 -> 64, idx 4 -> 16, idx 255 -> 255.
REQ-031 Backpressure: toggle out_ready every 3 cycles -> no lost or duplicated bins, dout stable during stalls, out_last only at idx 255.
REQ-032 Ping-pong: three back-to-back frames, out_ready=0 -> in_ready drops after beat 63 of frame 2 (both buffers full), resumes 1 cycle after the 256th output of frame 1.
REQ-033 in_last pulsed at beat 10 -> frame_err=1 and stays high; frame still outputs 256 bins.
REQ-034 Reset at input beat 30 -> out_valid=0, in_ready=1; the following full frame reorders correctly from buffer 0.
REQ-035 Random data vs. reference model (bin m = stored sample at digitrev(m)) over 20 frames with random valid/ready -> zero mismatches.

Source files
------------

// File: rtl/fft_out_reorder_pkg.sv
// rtl/fft_out_reorder_pkg.sv - shared widths and digit-reverse mapping for the FFT output reorder buffer
package fft_out_reorder_pkg;

   // Packed complex sample: {re, im}, each half of the word
   localparam int DATA_W_DEF = 34;
   localparam int NPOINT_DEF = 256;

   // Four butterfly lanes per beat, one bank per lane
   localparam int LANES = 4;

   // Row address within one bank (64 rows for a 256-point frame)
   localparam int ROW_W = 6;

   // Natural-order bin index width
   localparam int IDX_W = 8;

   // Radix-4 digit reversal: d3d2d1d0 -> d0d1d2d3.
   // Maps a natural-order bin index to the in-place address the
   // last butterfly stage wrote it to.
   function automatic logic [IDX_W-1:0] digit_rev(input logic [IDX_W-1:0] m);
      return {m[1:0], m[3:2], m[5:4], m[7:6]};
   endfunction

   // Bank holding an in-place address (the lane that produced it)
   function automatic logic [1:0] addr_bank(input logic [IDX_W-1:0] a);
      return a[1:0];
   endfunction

   // Row holding an in-place address (the beat that carried it)
   function automatic logic [ROW_W-1:0] addr_row(input logic [IDX_W-1:0] a);
      return a[7:2];
   endfunction

endpackage

// File: rtl/fft_out_reorder_bank.sv
// rtl/fft_out_reorder_bank.sv - one bank of a frame buffer: synchronous write, combinational read
module reorder_bank #(
   parameter int DATA_W = 34,
   parameter int ROWS   = 64,
   parameter int ROW_W  = 6
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ROW_W-1:0]  waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ROW_W-1:0]  raddr,
   output logic [DATA_W-1:0] rdata
);

   // Contents are never reset; a frame is only read once fully written
   logic [DATA_W-1:0] mem [ROWS];

   // Store one lane sample per accepted beat
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/fft_out_reorder.sv
// rtl/fft_out_reorder.sv - ping-pong buffer turning digit-reversed radix-4 FFT output into natural order
module fft_out_reorder
   import fft_out_reorder_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int NPOINT = NPOINT_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] din0,
   input  logic [DATA_W-1:0] din1,
   input  logic [DATA_W-1:0] din2,
   input  logic [DATA_W-1:0] din3,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] dout,
   output logic [IDX_W-1:0]  out_idx,
   output logic              out_last,
   output logic              frame_err
);

   // Rows per bank: one row per input beat
   localparam int ROWS = NPOINT / LANES;
   localparam logic [ROW_W-1:0] LAST_BEAT = ROW_W'(ROWS - 1);
   localparam logic [IDX_W-1:0] LAST_BIN  = IDX_W'(NPOINT - 1);

   logic              wr_sel;
   logic              rd_sel;
   logic [1:0]        full;
   logic [1:0]        full_next;
   logic [ROW_W-1:0]  beat;
   logic [IDX_W-1:0]  m;

   logic              accept;
   logic              drain;
   logic              last_beat;
   logic              last_bin;

   logic [IDX_W-1:0]  rd_addr;
   logic [1:0]        rd_bank;
   logic [ROW_W-1:0]  rd_row;

   logic [DATA_W-1:0] lane_wd [LANES];
   logic [DATA_W-1:0] bank_rd [2][LANES];

   assign lane_wd[0] = din0;
   assign lane_wd[1] = din1;
   assign lane_wd[2] = din2;
   assign lane_wd[3] = din3;

   // Handshakes: writer stalls only on a full target buffer, reader
   // presents data whenever its buffer holds a complete frame
   assign in_ready  = ~full[wr_sel];
   assign out_valid = full[rd_sel];
   assign accept    = in_valid && in_ready;
   assign drain     = out_valid && out_ready;
   assign last_beat = (beat == LAST_BEAT);
   assign last_bin  = (m == LAST_BIN);

   // Natural-order bin m lives at in-place address digit_rev(m)
   assign rd_addr = digit_rev(m);
   assign rd_bank = addr_bank(rd_addr);
   assign rd_row  = addr_row(rd_addr);

   assign dout     = bank_rd[rd_sel][rd_bank];
   assign out_idx  = m;
   assign out_last = out_valid && last_bin;

   // Two frame buffers, each four lane banks wide; lane k of beat b
   // lands in bank k, row b, i.e. in-place address 4*b + k
   for (genvar s = 0; s < 2; s++) begin : g_buf
      for (genvar k = 0; k < LANES; k++) begin : g_lane
         reorder_bank #(
            .DATA_W (DATA_W),
            .ROWS   (ROWS),
            .ROW_W  (ROW_W)
         ) u_bank (
            .clk   (clk),
            .we    (accept && (wr_sel == 1'(s))),
            .waddr (beat),
            .wdata (lane_wd[k]),
            .raddr (rd_row),
            .rdata (bank_rd[s][k])
         );
      end
   end

   // Frame-complete set and frame-drained clear may hit both buffers in one cycle
   always_comb begin
      full_next = full;
      if (accept && last_beat) begin
         full_next[wr_sel] = 1'b1;
      end
      if (drain && last_bin) begin
         full_next[rd_sel] = 1'b0;
      end
   end

   // Write side: beat counter and buffer select; frames end on the count, not in_last
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         beat   <= '0;
         wr_sel <= 1'b0;
      end else if (accept) begin
         if (last_beat) begin
            beat   <= '0;
            wr_sel <= ~wr_sel;
         end else begin
            beat <= beat + ROW_W'(1);
         end
      end
   end

   // Read side: bin counter and buffer select
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m      <= '0;
         rd_sel <= 1'b0;
      end else if (drain) begin
         m <= m + IDX_W'(1);
         if (last_bin) begin
            rd_sel <= ~rd_sel;
         end
      end
   end

   // Buffer occupancy flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full <= 2'b00;
      end else begin
         full <= full_next;
      end
   end

   // Sticky flag for in_last disagreeing with the beat count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_err <= 1'b0;
      end else if (accept && (in_last != last_beat)) begin
         frame_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_fft_out_reorder.sv
// tb/tb_fft_out_reorder.sv - self-checking bench for fft_out_reorder
module tb_fft_out_reorder;

   localparam int DW = 34;
   localparam int NF = 31;

   typedef struct {
      int idx;
      int exp_re;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] din [4];
   logic          in_last;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] dout;
   logic [7:0]    out_idx;
   logic          out_last;
   logic          frame_err;

   logic [DW-1:0] fdata [NF*256];
   logic [DW-1:0] cap [256];
   vec_t          tbl [10];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   fft_out_reorder #(
      .DATA_W (DW),
      .NPOINT (256)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .din0      (din[0]),
      .din1      (din[1]),
      .din2      (din[2]),
      .din3      (din[3]),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .dout      (dout),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .frame_err (frame_err)
   );

   // Reference address for bin m: base-4 digits of m read back to front
   function automatic int rev_tb(input int m);
      int a = 0;
      for (int i = 0; i < 4; i++) begin
         a = a * 4 + ((m >> (2 * i)) & 3);
      end
      return a;
   endfunction

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: cycle budget expired at %0t", name, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) din[k] = '0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic drive_beat(input int fr, input int b, input bit bad);
      for (int k = 0; k < 4; k++) din[k] = fdata[fr*256 + 4*b + k];
      in_last = (b == 63) || bad;
   endtask

   // Hand-driven beats with in_valid held high until each is accepted
   task automatic send_beats(input int fr, input int from, input int to);
      int w;
      for (int b = from; b <= to; b++) begin
         in_valid = 1'b1;
         drive_beat(fr, b, 1'b0);
         w = 0;
         while (!in_ready) begin
            tick();
            w++;
            if (w > 1000) begin
               timeout("send_beats");
               in_valid = 1'b0;
               return;
            end
         end
         tick();
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic producer(input int nfr, input int base, input int vpct, input int bad_beat);
      int  f = 0;
      int  b = 0;
      int  cyc = 0;
      bit  acc;
      while (f < nfr) begin
         if (cyc > 40000) begin
            timeout("producer");
            break;
         end
         in_valid = (int'($urandom_range(99)) < vpct);
         drive_beat(base + f, b, (f == 0) && (b == bad_beat));
         acc = in_valid && in_ready;
         tick();
         cyc++;
         if (acc) begin
            if (b == 63) begin
               b = 0;
               f++;
            end else begin
               b++;
            end
         end
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // rmode 0: random ready at rpct percent; rmode 1: ready toggles every 3 cycles
   task automatic consumer(input int ncf, input int base, input int rmode, input int rpct);
      int            f = 0;
      int            m = 0;
      int            cyc = 0;
      bit            rdy;
      bit            hs;
      bit            stall = 1'b0;
      logic [DW-1:0] pd = '0;
      logic [7:0]    pi = '0;
      while (f < ncf) begin
         if (cyc > 40000) begin
            timeout("consumer");
            break;
         end
         if (rmode == 1) rdy = ((cyc / 3) % 2) == 0;
         else            rdy = (int'($urandom_range(99)) < rpct);
         out_ready = rdy;
         if (stall) begin
            chk("stall_valid", longint'(out_valid), 1);
            chk("stall_dout", longint'(dout), longint'(pd));
            chk("stall_idx", longint'(out_idx), longint'(pi));
         end
         hs = out_valid && rdy;
         if (hs) begin
            chk("dout", longint'(dout), longint'(fdata[(base + f)*256 + rev_tb(m)]));
            chk("out_idx", longint'(out_idx), longint'(m));
            chk("out_last", longint'(out_last), longint'(m == 255));
            if (f == 0) cap[m] = dout;
         end
         stall = out_valid && !rdy;
         pd    = dout;
         pi    = out_idx;
         tick();
         cyc++;
         if (hs) begin
            if (m == 255) begin
               m = 0;
               f++;
            end else begin
               m++;
            end
         end
      end
      out_ready = 1'b0;
   endtask

   task automatic run(input int pn, input int pbase, input int cn, input int cbase,
                      input int vpct, input int rmode, input int rpct, input int bad_beat);
      fork
         producer(pn, pbase, vpct, bad_beat);
         consumer(cn, cbase, rmode, rpct);
      join
   endtask

   initial begin
      // Frame 0 is the ramp (re = in-place address, im = 0); the rest are random
      for (int a = 0; a < 256; a++) fdata[a] = {17'(a), 17'd0};
      for (int i = 256; i < NF*256; i++) fdata[i] = DW'({$urandom, $urandom});

      tbl[0] = '{idx: 0,   exp_re: 0};
      tbl[1] = '{idx: 1,   exp_re: 64};
      tbl[2] = '{idx: 2,   exp_re: 128};
      tbl[3] = '{idx: 3,   exp_re: 192};
      tbl[4] = '{idx: 4,   exp_re: 16};
      tbl[5] = '{idx: 16,  exp_re: 4};
      tbl[6] = '{idx: 64,  exp_re: 1};
      tbl[7] = '{idx: 27,  exp_re: 228};
      tbl[8] = '{idx: 128, exp_re: 2};
      tbl[9] = '{idx: 255, exp_re: 255};

      // Reset state
      do_reset();
      chk("rst_in_ready", longint'(in_ready), 1);
      chk("rst_out_valid", longint'(out_valid), 0);
      chk("rst_out_idx", longint'(out_idx), 0);
      chk("rst_out_last", longint'(out_last), 0);
      chk("rst_frame_err", longint'(frame_err), 0);

      // Ramp frame, then table of hand-computed bins
      run(1, 0, 1, 0, 100, 0, 100, -1);
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("ramp_re_idx%0d", tbl[i].idx), longint'(cap[tbl[i].idx][33:17]), longint'(tbl[i].exp_re));
         chk($sformatf("ramp_im_idx%0d", tbl[i].idx), longint'(cap[tbl[i].idx][16:0]), 0);
      end
      chk("ramp_frame_err", longint'(frame_err), 0);

      // Ping-pong: latency, both-full stall, resume after drain
      do_reset();
      send_beats(1, 0, 62);
      chk("pp_before_last", longint'(out_valid), 0);
      send_beats(1, 63, 63);
      chk("pp_latency_valid", longint'(out_valid), 1);
      chk("pp_first_idx", longint'(out_idx), 0);
      chk("pp_first_dout", longint'(dout), longint'(fdata[256]));
      chk("pp_second_free", longint'(in_ready), 1);
      send_beats(2, 0, 63);
      chk("pp_both_full", longint'(in_ready), 0);
      out_ready = 1'b1;
      for (int i = 0; i < 256; i++) begin
         if (i == 255) begin
            chk("pp_still_stalled", longint'(in_ready), 0);
            chk("pp_last_flag", longint'(out_last), 1);
            chk("pp_last_dout", longint'(dout), longint'(fdata[256 + 255]));
         end
         tick();
      end
      out_ready = 1'b0;
      chk("pp_resume", longint'(in_ready), 1);
      chk("pp_next_valid", longint'(out_valid), 1);
      chk("pp_next_idx", longint'(out_idx), 0);
      run(1, 3, 2, 2, 100, 0, 70, -1);

      // in_last misplaced at beat 10: sticky error, frame still complete
      do_reset();
      run(1, 4, 1, 4, 100, 0, 100, 10);
      chk("err_set", longint'(frame_err), 1);
      run(1, 5, 1, 5, 80, 0, 80, -1);
      chk("err_sticky", longint'(frame_err), 1);

      // Backpressure with ready toggling every 3 cycles
      do_reset();
      run(2, 6, 2, 6, 100, 1, 0, -1);

      // Reset during beat 30 with a complete frame pending
      do_reset();
      send_beats(8, 0, 63);
      send_beats(9, 0, 29);
      chk("mid_pending_valid", longint'(out_valid), 1);
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", longint'(out_valid), 0);
      chk("mid_rst_ready", longint'(in_ready), 1);
      tick();
      rst = 1'b0;
      chk("mid_rst_idx", longint'(out_idx), 0);
      run(1, 10, 1, 10, 100, 0, 100, -1);

      // Random data and handshakes over 20 frames
      do_reset();
      run(20, 11, 20, 11, 60, 0, 50, -1);
      chk("rand_frame_err", longint'(frame_err), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
